// File: rtl/mem_ctrl.sv
// Sequencing controller in front of the word-line decoder: accepts one request at a
// time, then walks the array through precharge, word-line access and sense capture.
module mem_ctrl #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 4,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              precharge,
  output logic              wl_en,
  output logic              bl_we,
  output logic [DATA_W-1:0] bl_wdata,
  input  logic [DATA_W-1:0] sense_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   dec_addr_q;
  logic [DATA_W-1:0]   bl_wdata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                precharge_q;
  logic                wl_en_q;
  logic                bl_we_q;
  logic                rsp_valid_q;

  // Ready is a pure decode of the state register, gated by reset so a request held
  // through reset is taken on the very first edge after release.
  assign req_ready = (state_q == IDLE) && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      dec_addr_q  <= '0;
      bl_wdata_q  <= '0;
      rsp_rdata_q <= '0;
      precharge_q <= 1'b0;
      wl_en_q     <= 1'b0;
      bl_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            dec_addr_q  <= req_addr;
            bl_wdata_q  <= req_wdata;
            we_q        <= req_we;
            precharge_q <= 1'b1;
            state_q     <= PRE;
          end
        end
        PRE: begin
          precharge_q <= 1'b0;
          wl_en_q     <= 1'b1;
          bl_we_q     <= we_q;
          cnt_q       <= '0;
          state_q     <= ACC;
        end
        ACC: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            wl_en_q     <= 1'b0;
            bl_we_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (!we_q) rsp_rdata_q <= sense_data;
            state_q     <= DONE;
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_addr  = dec_addr_q;
  assign bl_wdata  = bl_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign precharge = precharge_q;
  assign wl_en     = wl_en_q;
  assign bl_we     = bl_we_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: per-cycle vector table on the default build plus
// hand-written reset, mid-access reset and single-cycle-access sequences.
module tb_mem_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid, req_we, req_ready;
  logic [2:0] req_addr, dec_addr;
  logic [3:0] req_wdata, bl_wdata, sense_data, rsp_rdata;
  logic       precharge, wl_en, bl_we, rsp_valid;

  logic       req_valid1, req_we1, req_ready1;
  logic [2:0] req_addr1, dec_addr1;
  logic [3:0] req_wdata1, bl_wdata1, sense_data1, rsp_rdata1;
  logic       precharge1, wl_en1, bl_we1, rsp_valid1;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .dec_addr(dec_addr), .precharge(precharge), .wl_en(wl_en), .bl_we(bl_we),
    .bl_wdata(bl_wdata), .sense_data(sense_data), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata)
  );

  mem_ctrl #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .dec_addr(dec_addr1), .precharge(precharge1), .wl_en(wl_en1), .bl_we(bl_we1),
    .bl_wdata(bl_wdata1), .sense_data(sense_data1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Invariant and decoder-address-stability monitor, evaluated every cycle.
  logic       acc_seen;
  logic [2:0] prev_dec;
  always @(posedge clk) acc_seen = req_valid & req_ready;
  always @(negedge clk) begin
    if (rst) begin
      prev_dec = 3'd0;
    end else begin
      check("inv_pre_and_wl", precharge & wl_en, 0);
      check("inv_blwe_needs_wl", bl_we & ~wl_en, 0);
      check("inv_rsp_only_done", rsp_valid & (wl_en | precharge | req_ready), 0);
      check("inv1_pre_and_wl", precharge1 & wl_en1, 0);
      check("inv1_blwe_needs_wl", bl_we1 & ~wl_en1, 0);
      if (!acc_seen) check("dec_addr_hold", dec_addr, prev_dec);
      prev_dec = dec_addr;
    end
  end

  typedef struct {
    logic       v, we;
    logic [2:0] addr;
    logic [3:0] wd, sense;
    logic       rdy;
    logic [2:0] dec;
    logic       pre, wl, blwe;
    logic [3:0] blwd;
    logic       rv;
    logic [3:0] rd;
  } vec_t;

  function automatic vec_t mk(logic v, logic we, logic [2:0] a, logic [3:0] wd,
                              logic [3:0] s, logic rdy, logic [2:0] dec, logic pre,
                              logic wl, logic blwe, logic [3:0] blwd, logic rv,
                              logic [3:0] rd);
    vec_t t;
    t.v = v; t.we = we; t.addr = a; t.wd = wd; t.sense = s;
    t.rdy = rdy; t.dec = dec; t.pre = pre; t.wl = wl; t.blwe = blwe;
    t.blwd = blwd; t.rv = rv; t.rd = rd;
    return t;
  endfunction

  vec_t vecs [25];

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;

    // Inputs (v we addr wd sense) -> outputs after the edge (rdy dec pre wl blwe blwd rv rd)
    // Write 5 <- A
    vecs[0]  = mk(1,1,3'd5,4'hA,4'hF, 0,3'd5,1,0,0,4'hA,0,4'h0);
    vecs[1]  = mk(0,0,3'd6,4'hE,4'hF, 0,3'd5,0,1,1,4'hA,0,4'h0);
    vecs[2]  = mk(0,0,3'd6,4'hE,4'hF, 0,3'd5,0,1,1,4'hA,0,4'h0);
    vecs[3]  = mk(0,0,3'd6,4'hE,4'hF, 0,3'd5,0,0,0,4'hA,1,4'h0);
    vecs[4]  = mk(0,0,3'd6,4'hE,4'hF, 1,3'd5,0,0,0,4'hA,0,4'h0);
    // Read 5, sense 6 only in the final access cycle
    vecs[5]  = mk(1,0,3'd5,4'h3,4'hF, 0,3'd5,1,0,0,4'h3,0,4'h0);
    vecs[6]  = mk(0,0,3'd6,4'hE,4'hF, 0,3'd5,0,1,0,4'h3,0,4'h0);
    vecs[7]  = mk(0,0,3'd6,4'hE,4'hF, 0,3'd5,0,1,0,4'h3,0,4'h0);
    vecs[8]  = mk(0,0,3'd6,4'hE,4'h6, 0,3'd5,0,0,0,4'h3,1,4'h6);
    vecs[9]  = mk(0,0,3'd6,4'hE,4'hF, 1,3'd5,0,0,0,4'h3,0,4'h6);
    // Write 2 <- 9 leaves read data untouched
    vecs[10] = mk(1,1,3'd2,4'h9,4'hF, 0,3'd2,1,0,0,4'h9,0,4'h6);
    vecs[11] = mk(0,0,3'd6,4'hE,4'hF, 0,3'd2,0,1,1,4'h9,0,4'h6);
    vecs[12] = mk(0,0,3'd6,4'hE,4'hF, 0,3'd2,0,1,1,4'h9,0,4'h6);
    vecs[13] = mk(0,0,3'd6,4'hE,4'hF, 0,3'd2,0,0,0,4'h9,1,4'h6);
    vecs[14] = mk(0,0,3'd6,4'hE,4'hF, 1,3'd2,0,0,0,4'h9,0,4'h6);
    // Back-to-back reads with req_valid held: addr 0, then addr 7 waits for IDLE
    vecs[15] = mk(1,0,3'd0,4'h1,4'h0, 0,3'd0,1,0,0,4'h1,0,4'h6);
    vecs[16] = mk(1,0,3'd7,4'h4,4'h0, 0,3'd0,0,1,0,4'h1,0,4'h6);
    vecs[17] = mk(1,0,3'd7,4'h4,4'h0, 0,3'd0,0,1,0,4'h1,0,4'h6);
    vecs[18] = mk(1,0,3'd7,4'h4,4'h5, 0,3'd0,0,0,0,4'h1,1,4'h5);
    vecs[19] = mk(1,0,3'd7,4'h4,4'hF, 1,3'd0,0,0,0,4'h1,0,4'h5);
    vecs[20] = mk(1,0,3'd7,4'h4,4'hF, 0,3'd7,1,0,0,4'h4,0,4'h5);
    vecs[21] = mk(0,0,3'd6,4'hE,4'hF, 0,3'd7,0,1,0,4'h4,0,4'h5);
    vecs[22] = mk(0,0,3'd6,4'hE,4'hF, 0,3'd7,0,1,0,4'h4,0,4'h5);
    vecs[23] = mk(0,0,3'd6,4'hE,4'h3, 0,3'd7,0,0,0,4'h4,1,4'h3);
    vecs[24] = mk(0,0,3'd6,4'hE,4'hF, 1,3'd7,0,0,0,4'h4,0,4'h3);

    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 4'h2; sense_data = 4'h0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 3'd0; req_wdata1 = 4'h0; sense_data1 = 4'h0;

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_dec_addr",  dec_addr, 0);
    check("rst_precharge", precharge, 0);
    check("rst_wl_en",     wl_en, 0);
    check("rst_bl_we",     bl_we, 0);
    check("rst_bl_wdata",  bl_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst1_req_ready", req_ready1, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("release_req_ready", req_ready, 1);
    // The request held through reset is taken on the first edge after release.
    cycle();
    check("held_req_dec_addr", dec_addr, 1);
    check("held_req_bl_wdata", bl_wdata, 2);
    check("held_req_precharge", precharge, 1);
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin
      cycle();
      n++;
    end
    check("held_req_ready_return", req_ready, 1);
    check("held_req_write_rdata", rsp_rdata, 0);

    for (int i = 0; i < 25; i++) begin
      req_valid  = vecs[i].v;
      req_we     = vecs[i].we;
      req_addr   = vecs[i].addr;
      req_wdata  = vecs[i].wd;
      sense_data = vecs[i].sense;
      cycle();
      check($sformatf("v%0d_req_ready", i), req_ready, vecs[i].rdy);
      check($sformatf("v%0d_dec_addr", i),  dec_addr,  vecs[i].dec);
      check($sformatf("v%0d_precharge", i), precharge, vecs[i].pre);
      check($sformatf("v%0d_wl_en", i),     wl_en,     vecs[i].wl);
      check($sformatf("v%0d_bl_we", i),     bl_we,     vecs[i].blwe);
      check($sformatf("v%0d_bl_wdata", i),  bl_wdata,  vecs[i].blwd);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].rv);
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].rd);
    end

    // Reset during the first access cycle of a write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 4'hC; sense_data = 4'h0;
    cycle();
    req_valid = 1'b0;
    cycle();
    check("midacc_wl_before", wl_en, 1);
    check("midacc_blwe_before", bl_we, 1);
    #2 rst = 1'b1;
    #1;
    check("midacc_wl_drop", wl_en, 0);
    check("midacc_blwe_drop", bl_we, 0);
    check("midacc_precharge", precharge, 0);
    check("midacc_dec_addr", dec_addr, 0);
    check("midacc_bl_wdata", bl_wdata, 0);
    check("midacc_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (rsp_valid) seen = 1'b1;
    end
    check("midacc_no_rsp", seen, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd4; sense_data = 4'h7;
    cycle();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 12) begin
      cycle();
      n++;
    end
    check("midacc_read_rsp", rsp_valid, 1);
    check("midacc_read_data", rsp_rdata, 4'h7);
    cycle();

    // Single-cycle access build: sweep all word addresses.
    for (int a = 0; a < 8; a++) begin
      req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 3'(a); sense_data1 = 4'(a) ^ 4'h5;
      cycle();
      check($sformatf("ac1_a%0d_dec_addr", a), dec_addr1, a);
      check($sformatf("ac1_a%0d_precharge", a), precharge1, 1);
      req_valid1 = 1'b0;
      cycle();
      check($sformatf("ac1_a%0d_wl_on", a), wl_en1, 1);
      cycle();
      check($sformatf("ac1_a%0d_wl_off", a), wl_en1, 0);
      check($sformatf("ac1_a%0d_rsp_valid", a), rsp_valid1, 1);
      check($sformatf("ac1_a%0d_rsp_rdata", a), rsp_rdata1, 4'(a) ^ 4'h5);
      cycle();
      check($sformatf("ac1_a%0d_ready", a), req_ready1, 1);
      check($sformatf("ac1_a%0d_rsp_end", a), rsp_valid1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
